// File: rtl/tt_seq_pkg.sv
// Shared types for the truth-table vector sequencer: FSM state encoding and vector-count helper.
package tt_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        SAMPLE,
        DONE
    } tt_state_t;

    function automatic int n_vec(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-time down-counter: load a start value, decrement to zero, flag when zero.
module tt_settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/tt_vector_sequencer.sv
// Clocked self-checking truth-table sweep for small combinational gates.
// Optional feature macro: TT_FIRST_ERR_EN adds first_err/first_err_vld reporting.
module tt_vector_sequencer
    import tt_seq_pkg::*;
#(
    parameter int                    N_IN   = 2,
    parameter int                    SETTLE = 1,
    parameter logic [(2**N_IN)-1:0]  EXPECT = 4'b1110
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic [N_IN-1:0]         vec,
    input  logic                    s,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [(2**N_IN)-1:0]    truth_table,
    output logic [N_IN:0]           err_cnt
`ifdef TT_FIRST_ERR_EN
    ,
    output logic [N_IN-1:0]         first_err,
    output logic                    first_err_vld
`endif
);

    localparam int N_VEC = n_vec(N_IN);
    localparam int CW    = $clog2(SETTLE + 1);
    localparam logic [CW-1:0]   SETTLE_LD = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] IDX_LAST  = N_IN'(N_VEC - 1);

    tt_state_t          state_q, state_d;
    logic [N_IN-1:0]    idx_q, idx_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [N_VEC-1:0]   table_q, table_d;
    logic [N_IN:0]      err_q, err_d;
    logic               timer_load, timer_dec, timer_zero;
`ifdef TT_FIRST_ERR_EN
    logic [N_IN-1:0]    ferr_q, ferr_d;
    logic               ferr_vld_q, ferr_vld_d;
`endif

    tt_settle_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .dec      (timer_dec),
        .load_val (SETTLE_LD),
        .zero     (timer_zero)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        vec_d      = vec_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        table_d    = table_q;
        err_d      = err_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
`ifdef TT_FIRST_ERR_EN
        ferr_d     = ferr_q;
        ferr_vld_d = ferr_vld_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    table_d = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
`ifdef TT_FIRST_ERR_EN
                    ferr_d     = '0;
                    ferr_vld_d = 1'b0;
`endif
                end
            end
            DRIVE: begin
                vec_d      = idx_q;
                timer_load = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (timer_zero) begin
                    state_d = SAMPLE;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            SAMPLE: begin
                // s is only trusted here; any X elsewhere never reaches the table
                table_d[idx_q] = s;
                if (s != EXPECT[idx_q]) begin
                    err_d = err_q + (N_IN+1)'(1);
`ifdef TT_FIRST_ERR_EN
                    if (!ferr_vld_q) begin
                        ferr_d     = idx_q;
                        ferr_vld_d = 1'b1;
                    end
`endif
                end
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    idx_d   = idx_q + N_IN'(1);
                    state_d = DRIVE;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                vec_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            vec_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            table_q    <= '0;
            err_q      <= '0;
`ifdef TT_FIRST_ERR_EN
            ferr_q     <= '0;
            ferr_vld_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            vec_q      <= vec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            table_q    <= table_d;
            err_q      <= err_d;
`ifdef TT_FIRST_ERR_EN
            ferr_q     <= ferr_d;
            ferr_vld_q <= ferr_vld_d;
`endif
        end
    end

    assign vec         = vec_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign truth_table = table_q;
    assign err_cnt     = err_q;
`ifdef TT_FIRST_ERR_EN
    assign first_err     = ferr_q;
    assign first_err_vld = ferr_vld_q;
`endif

endmodule
